ex_simple_pipe: RTL and testbench

// Parametrised, pipelined execute unit for the "simple" FU. Picks the oldest operand-ready

---
 rtl/ex_simple_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_ex_simple_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_simple_pipe.sv
// rtl/ex_simple_pipe.sv - oldest-ready select, E1 register, shared alu and WB register for the simple FU

// Shared combinational alu. Undefined opcodes produce zero.
module ex_simple_alu #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [XLEN-1:0]    aluin1,
  input  logic [XLEN-1:0]    aluin2,
  output logic [XLEN-1:0]    aluout
);
  localparam int SH_W = $clog2(XLEN);

  localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(9);

  logic [SH_W-1:0] shamt;
  assign shamt = aluin2[SH_W-1:0];

  // Result is computed at XLEN; any carry out of the adder is dropped.
  always_comb begin
    aluout = '0;
    case (aluop)
      OP_ADD:  aluout = aluin1 + aluin2;
      OP_SUB:  aluout = aluin1 - aluin2;
      OP_AND:  aluout = aluin1 & aluin2;
      OP_OR:   aluout = aluin1 | aluin2;
      OP_XOR:  aluout = aluin1 ^ aluin2;
      OP_SLL:  aluout = aluin1 << shamt;
      OP_SRL:  aluout = aluin1 >> shamt;
      OP_SRA:  aluout = $unsigned($signed(aluin1) >>> shamt);
      OP_SLT:  aluout = {{(XLEN-1){1'b0}}, ($signed(aluin1) < $signed(aluin2))};
      OP_SLTU: aluout = {{(XLEN-1){1'b0}}, (aluin1 < aluin2)};
      default: aluout = '0;
    endcase
  end
endmodule

// Execute pipe: select -> E1 -> alu -> WB, with valid/ready backpressure on WB.
module ex_simple_pipe #(
  parameter int XLEN    = 32,
  parameter int NUM_RS  = 4,
  parameter int TAG_W   = 4,
  parameter int AGE_W   = 3,
  parameter int ALUOP_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_RS-1:0]         rs_valid,
  input  logic [NUM_RS-1:0]         rs_src1_rdy,
  input  logic [NUM_RS-1:0]         rs_src2_rdy,
  input  logic [NUM_RS*XLEN-1:0]    rs_src1,
  input  logic [NUM_RS*XLEN-1:0]    rs_src2,
  input  logic [NUM_RS*ALUOP_W-1:0] rs_aluop,
  input  logic [NUM_RS*5-1:0]       rs_rd,
  input  logic [NUM_RS-1:0]         rs_regwrite,
  input  logic [NUM_RS*TAG_W-1:0]   rs_tag,
  input  logic [NUM_RS*AGE_W-1:0]   rs_age,
  output logic [NUM_RS-1:0]         issue_grant,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [XLEN-1:0]           wb_data,
  output logic [4:0]                wb_rd,
  output logic                      wb_regwrite,
  output logic [TAG_W-1:0]          wb_tag,
  output logic                      rf_we,
  output logic [15:0]               perf_stall_cnt
);
  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_RS-1:0]  rdy;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [AGE_W-1:0]   sel_age;
  logic [XLEN-1:0]    sel_src1;
  logic [XLEN-1:0]    sel_src2;
  logic [ALUOP_W-1:0] sel_aluop;
  logic [4:0]         sel_rd;
  logic               sel_regwrite;
  logic [TAG_W-1:0]   sel_tag;

  logic               e1_valid;
  logic [XLEN-1:0]    e1_src1;
  logic [XLEN-1:0]    e1_src2;
  logic [ALUOP_W-1:0] e1_aluop;
  logic [4:0]         e1_rd;
  logic               e1_regwrite;
  logic [TAG_W-1:0]   e1_tag;
  logic [XLEN-1:0]    alu_out;

  logic wb_fire;
  logic wb_adv;
  logic e1_adv;

  assign rdy     = rs_valid & rs_src1_rdy & rs_src2_rdy;
  assign wb_fire = wb_valid & wb_ready;
  assign wb_adv  = !wb_valid | wb_ready;
  assign e1_adv  = !e1_valid | wb_adv;

  // Oldest-ready pick: strict less-than keeps the lowest index on equal ages.
  always_comb begin
    sel_found    = 1'b0;
    sel_idx      = '0;
    sel_age      = '0;
    sel_src1     = '0;
    sel_src2     = '0;
    sel_aluop    = '0;
    sel_rd       = '0;
    sel_regwrite = 1'b0;
    sel_tag      = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (rdy[i] && (!sel_found || (rs_age[i*AGE_W +: AGE_W] < sel_age))) begin
        sel_found    = 1'b1;
        sel_idx      = IDX_W'(i);
        sel_age      = rs_age[i*AGE_W +: AGE_W];
        sel_src1     = rs_src1[i*XLEN +: XLEN];
        sel_src2     = rs_src2[i*XLEN +: XLEN];
        sel_aluop    = rs_aluop[i*ALUOP_W +: ALUOP_W];
        sel_rd       = rs_rd[i*5 +: 5];
        sel_regwrite = rs_regwrite[i];
        sel_tag      = rs_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Grant only when E1 can take it; reset and flush both suppress issue.
  always_comb begin
    issue_grant = '0;
    if (sel_found && e1_adv && !flush && rst_n) begin
      issue_grant = {{(NUM_RS-1){1'b0}}, 1'b1} << sel_idx;
    end
  end

  // E1 stage: capture the granted entry, or take a bubble when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_valid    <= 1'b0;
      e1_src1     <= '0;
      e1_src2     <= '0;
      e1_aluop    <= '0;
      e1_rd       <= '0;
      e1_regwrite <= 1'b0;
      e1_tag      <= '0;
    end else if (flush) begin
      e1_valid <= 1'b0;
    end else if (e1_adv) begin
      e1_valid <= |issue_grant;
      if (|issue_grant) begin
        e1_src1     <= sel_src1;
        e1_src2     <= sel_src2;
        e1_aluop    <= sel_aluop;
        e1_rd       <= sel_rd;
        e1_regwrite <= sel_regwrite;
        e1_tag      <= sel_tag;
      end
    end
  end

  ex_simple_alu #(
    .XLEN    (XLEN),
    .ALUOP_W (ALUOP_W)
  ) u_alu (
    .aluop  (e1_aluop),
    .aluin1 (e1_src1),
    .aluin2 (e1_src2),
    .aluout (alu_out)
  );

  // WB stage: holds the result stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      wb_tag      <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (wb_adv) begin
      wb_valid <= e1_valid;
      if (e1_valid) begin
        wb_data     <= alu_out;
        wb_rd       <= e1_rd;
        wb_regwrite <= e1_regwrite;
        wb_tag      <= e1_tag;
      end
    end
  end

  // x0 results still go to the ROB but never write the RF.
  assign rf_we = wb_fire & wb_regwrite & (wb_rd != 5'd0);

  // Saturating backpressure counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if (wb_valid && !wb_ready && (perf_stall_cnt != 16'hFFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_ex_simple_pipe.sv
// tb/tb_ex_simple_pipe.sv - randomized scoreboard bench for ex_simple_pipe
module tb_ex_simple_pipe;
  localparam int XLEN = 32;
  localparam int NRS  = 4;
  localparam int TW   = 4;
  localparam int AW   = 3;
  localparam int OW   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [NRS-1:0]    rs_valid = '0;
  logic [NRS-1:0]    rs_src1_rdy = '0;
  logic [NRS-1:0]    rs_src2_rdy = '0;
  logic [NRS*XLEN-1:0] rs_src1 = '0;
  logic [NRS*XLEN-1:0] rs_src2 = '0;
  logic [NRS*OW-1:0] rs_aluop = '0;
  logic [NRS*5-1:0]  rs_rd = '0;
  logic [NRS-1:0]    rs_regwrite = '0;
  logic [NRS*TW-1:0] rs_tag = '0;
  logic [NRS*AW-1:0] rs_age = '0;
  logic [NRS-1:0]    issue_grant;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [XLEN-1:0]   wb_data;
  logic [4:0]        wb_rd;
  logic              wb_regwrite;
  logic [TW-1:0]     wb_tag;
  logic              rf_we;
  logic [15:0]       perf_stall_cnt;

  always #5 clk = ~clk;

  ex_simple_pipe #(.XLEN(XLEN), .NUM_RS(NRS), .TAG_W(TW), .AGE_W(AW), .ALUOP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rs_valid(rs_valid), .rs_src1_rdy(rs_src1_rdy), .rs_src2_rdy(rs_src2_rdy),
    .rs_src1(rs_src1), .rs_src2(rs_src2), .rs_aluop(rs_aluop), .rs_rd(rs_rd),
    .rs_regwrite(rs_regwrite), .rs_tag(rs_tag), .rs_age(rs_age),
    .issue_grant(issue_grant), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_tag(wb_tag),
    .rf_we(rf_we), .perf_stall_cnt(perf_stall_cnt)
  );

  typedef struct {
    logic        v, r1, r2;
    logic [31:0] a, b;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic [3:0]  tag;
    logic [2:0]  age;
  } slot_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic [3:0]  tag;
    int          gcyc;
  } exp_t;

  slot_t slots[NRS];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    model_stall = 0;
  logic [NRS-1:0] last_grant;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return a << b[4:0];
      5'd6: return a >> b[4:0];
      5'd7: return $unsigned($signed(a) >>> b[4:0]);
      5'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Oldest ready slot: find the minimum age first, then the first slot holding it.
  function automatic int pick();
    int best = 8;
    for (int i = 0; i < NRS; i++)
      if (slots[i].v && slots[i].r1 && slots[i].r2 && int'(slots[i].age) < best) best = int'(slots[i].age);
    for (int i = 0; i < NRS; i++)
      if (slots[i].v && slots[i].r1 && slots[i].r2 && int'(slots[i].age) == best) return i;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NRS; i++) begin
      rs_valid[i]            = slots[i].v;
      rs_src1_rdy[i]         = slots[i].r1;
      rs_src2_rdy[i]         = slots[i].r2;
      rs_src1[i*XLEN +: XLEN] = slots[i].a;
      rs_src2[i*XLEN +: XLEN] = slots[i].b;
      rs_aluop[i*OW +: OW]   = slots[i].op;
      rs_rd[i*5 +: 5]        = slots[i].rd;
      rs_regwrite[i]         = slots[i].rw;
      rs_tag[i*TW +: TW]     = slots[i].tag;
      rs_age[i*AW +: AW]     = slots[i].age;
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NRS; i++) slots[i] = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 4'd0, 3'd0};
  endtask

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                          input logic [4:0] rd, input logic rw, input logic [3:0] tag, input logic [2:0] age);
    slots[i] = '{1'b1, 1'b1, 1'b1, a, b, op, rd, rw, tag, age};
  endtask

  // One cycle of the RS/ROB environment: drive, predict and check the grant, retire flushed work.
  task automatic step(input logic rdy, input logic fl);
    int p;
    logic allow;
    logic [NRS-1:0] eg;
    exp_t e;
    @(negedge clk);
    wb_ready = rdy;
    flush = fl;
    drive();
    #2;
    p = pick();
    allow = ((sb.size() < 2) || rdy) && !fl;
    eg = '0;
    if (p >= 0 && allow) eg[p] = 1'b1;
    last_grant = issue_grant;
    check("grant", issue_grant, eg);
    if (eg != '0) begin
      e.data = alu_ref(slots[p].op, slots[p].a, slots[p].b);
      e.rd = slots[p].rd;
      e.rw = slots[p].rw;
      e.tag = slots[p].tag;
      e.gcyc = cyc;
      sb.push_back(e);
      slots[p].v = 1'b0;
    end
    #2;
    if (fl) sb.delete();
  endtask

  task automatic check_perf(input string name);
    @(posedge clk);
    #1;
    check(name, perf_stall_cnt, model_stall);
  endtask

  // Monitor: the head of the scoreboard must be presented two cycles after its grant.
  always @(negedge clk) begin
    logic ev;
    logic erf;
    #3;
    if (rst_n) begin
      ev = (sb.size() > 0) && (cyc - sb[0].gcyc >= 2);
      check("wb_valid", wb_valid, ev);
      erf = 1'b0;
      if (ev) begin
        check("wb_data", wb_data, sb[0].data);
        check("wb_tag", wb_tag, sb[0].tag);
        check("wb_rd", wb_rd, sb[0].rd);
        check("wb_regwrite", wb_regwrite, sb[0].rw);
        erf = wb_ready && sb[0].rw && (sb[0].rd != 5'd0);
      end
      check("rf_we", rf_we, erf);
      if (ev && !wb_ready && model_stall < 65535) model_stall++;
      if (ev && wb_ready) void'(sb.pop_front());
    end
  end

  initial begin
    int base;
    clear_slots();
    drive();
    #1;
    check("rst_grant", issue_grant, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_perf", perf_stall_cnt, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_rf_we", rf_we, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single op
    set_slot(2, 32'd5, 32'd7, 5'd0, 5'd4, 1'b1, 4'd3, 3'd0);
    step(1'b1, 1'b0);
    check("single_grant", last_grant, 4'b0100);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("single_valid", wb_valid, 1);
    check("single_data", wb_data, 12);
    check("single_tag", wb_tag, 3);
    check("single_rf_we", rf_we, 1);

    // age select
    clear_slots();
    set_slot(0, 32'd1, 32'd2, 5'd0, 5'd1, 1'b1, 4'd0, 3'd5);
    set_slot(1, 32'd3, 32'd4, 5'd1, 5'd2, 1'b1, 4'd1, 3'd2);
    set_slot(3, 32'd9, 32'd6, 5'd4, 5'd3, 1'b1, 4'd2, 3'd2);
    step(1'b1, 1'b0);
    check("age_sel0", last_grant, 4'b0010);
    step(1'b1, 1'b0);
    check("age_sel1", last_grant, 4'b1000);
    step(1'b1, 1'b0);
    check("age_sel2", last_grant, 4'b0001);
    repeat (3) step(1'b1, 1'b0);

    // x0 destination
    set_slot(1, 32'd8, 32'd8, 5'd0, 5'd0, 1'b1, 4'd7, 3'd1);
    repeat (4) step(1'b1, 1'b0);

    // backpressure
    base = model_stall;
    set_slot(0, 32'd10, 32'd1, 5'd1, 5'd5, 1'b1, 4'd8, 3'd0);
    set_slot(1, 32'd20, 32'd2, 5'd2, 5'd6, 1'b1, 4'd9, 3'd1);
    set_slot(2, 32'd30, 32'd3, 5'd3, 5'd7, 1'b0, 4'd10, 3'd2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (4) begin
      step(1'b0, 1'b0);
      check("bp_grant_blocked", last_grant, 0);
    end
    repeat (5) step(1'b1, 1'b0);
    check_perf("bp_perf_model");
    check("bp_perf_four", perf_stall_cnt, base + 4);
    check("bp_drained", sb.size(), 0);

    // flush with E1 and WB full and wb_ready low
    set_slot(0, 32'd1, 32'd1, 5'd0, 5'd9, 1'b1, 4'd1, 3'd0);
    set_slot(1, 32'd2, 32'd2, 5'd0, 5'd10, 1'b1, 4'd2, 3'd1);
    set_slot(2, 32'd3, 32'd3, 5'd0, 5'd11, 1'b1, 4'd3, 3'd2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("flush_grant", last_grant, 0);
    step(1'b1, 1'b0);
    check("flush_wb_valid", wb_valid, 0);
    check("flush_regrant", last_grant, 4'b0100);
    repeat (3) step(1'b1, 1'b0);

    // async reset mid-stream
    set_slot(0, 32'd4, 32'd4, 5'd0, 5'd1, 1'b1, 4'd4, 3'd0);
    set_slot(1, 32'd5, 32'd5, 5'd0, 5'd2, 1'b1, 4'd5, 3'd1);
    set_slot(3, 32'd6, 32'd6, 5'd0, 5'd3, 1'b1, 4'd6, 3'd2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    @(negedge clk);
    drive();
    wb_ready = 1'b1;
    #4 rst_n = 1'b0;
    sb.delete();
    model_stall = 0;
    #1;
    check("mrst_grant", issue_grant, 0);
    check("mrst_wb_valid", wb_valid, 0);
    check("mrst_wb_data", wb_data, 0);
    check("mrst_wb_tag", wb_tag, 0);
    check("mrst_rf_we", rf_we, 0);
    check("mrst_perf", perf_stall_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0);
    check("mrst_first_grant", last_grant != 0, 1);
    repeat (4) step(1'b1, 1'b0);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NRS; i++) begin
        if (!slots[i].v && ($urandom % 3 == 0)) begin
          slots[i].v   = 1'b1;
          slots[i].r1  = ($urandom % 4) != 0;
          slots[i].r2  = ($urandom % 4) != 0;
          slots[i].a   = $urandom;
          slots[i].b   = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 40));
          slots[i].op  = 5'($urandom_range(0, 11));
          slots[i].rd  = 5'($urandom_range(0, 31));
          slots[i].rw  = 1'($urandom);
          slots[i].tag = 4'($urandom);
          slots[i].age = 3'($urandom);
        end else if (slots[i].v) begin
          if ($urandom % 3 == 0) slots[i].r1 = 1'b1;
          if ($urandom % 3 == 0) slots[i].r2 = 1'b1;
        end
      end
      step(($urandom % 4) != 0, ($urandom % 50) == 0);
    end

    clear_slots();
    repeat (6) step(1'b1, 1'b0);
    check("final_drained", sb.size(), 0);
    check_perf("final_perf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
